sccb_slave_regfile: RTL and testbench
=====================================

// Module: sccb_slave_regfile
// PURPOSE
//  SCCB/I2C responder (slave) with an internal 8-bit register file: the far end of IICctrl.
//  Decodes 3-phase writes (dev addr, sub addr, data) and 2-phase reads (dev addr|R, data).
//  Used as a camera-sensor (OV7670-style) stand-in for benches, and as an on-chip config target.
//  Oversampled design: SCL/SDA are sampled on iCLK. Not clocked by SCL.
// PARAMETERS
//  SLAVE_ADDR  8'h42  8-bit write address. Read address = SLAVE_ADDR|1. Bit 0 of the parameter is ignored.
//  REG_DEPTH   256    register-file entries. Power of 2, <=256. Sub-address uses the low log2(REG_DEPTH) bits.
//  RST_VAL     8'h00  reset value of every register entry.
// PORTS
//  iCLK       in     1  system clock; must be >= 8x SCL frequency.
//  rst_n      in     1  asynchronous, active-low reset.
//  I2C_SCLK   in     1  bus clock from the master (this block never stretches the clock).
//  I2C_SDAT   inout  1  open-drain data; driven 1'b0 or 1'bz, never 1'b1.
//  wr_strobe  out    1  one-cycle pulse per accepted data byte written.
//  wr_addr    out    8  sub-address of that write; valid with wr_strobe.
//  wr_data    out    8  data of that write; valid with wr_strobe.
//  busy       out    1  high from an addressed START to the following STOP.
// BEHAVIOUR
//  Reset (async, rst_n=0): SDA released (z), FSM=IDLE, sub_addr=0, all regs=RST_VAL, wr_*=0, busy=0.
//   Reset asserted mid-transfer releases SDA immediately, with no clock.
//  Input sampling: 2-flop synchroniser on SCL and SDA, then a 1-cycle edge detector.
//   SCL rise is detected 3 iCLK after the pin edge.
//  Bus conditions (detected while sync SCL=1): START = SDA fall; STOP = SDA rise.
//   START in any state -> DEV_ADDR, bit count = 0. This covers repeated START.
//   STOP in any state -> IDLE, SDA released, busy=0.
//  Data in: shift SDA MSB-first on each SCL rise.
//  Data out: SDA output changes only on detected SCL fall, never while SCL is high.
//  ACK slot: after the 8th data SCL fall, drive SDA low; release it on the next SCL fall.
//  FSM states: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
//  DEV_ADDR, 8 bits received:
//   byte[7:1] != SLAVE_ADDR[7:1] -> IGNORE. No ACK; SDA stays z until the next START/STOP.
//   match with R/W=0 -> DEV_ACK -> SUB_ADDR.
//   match with R/W=1 -> DEV_ACK, load shift register <= reg[sub_addr] -> RD_DATA.
//  SUB_ADDR, 8 bits received: sub_addr <= byte; SUB_ACK -> WR_DATA.
//  WR_DATA, 8 bits received:
//   reg[sub_addr] <= byte; pulse wr_strobe with wr_addr=sub_addr, wr_data=byte. This happens on the same cycle as the 8th rise.
//   sub_addr <= sub_addr+1, wrapping at REG_DEPTH-1 -> 0; WR_ACK -> WR_DATA (burst).
//  RD_DATA: drive 8 bits MSB first (0 -> drive low, 1 -> z), then release SDA -> RD_ACK.
//  RD_ACK: sample master ACK on SCL rise.
//   ACK (0): sub_addr++ (wrapping), load next byte -> RD_DATA.
//   NACK (1): -> IGNORE, waiting for STOP/START.
//  sub_addr persists across transactions. SCCB read = write(dev, sub) STOP, then START read.
//  A data byte cut short by START/STOP before its 8th bit is discarded. No register or wr_strobe change.
//  busy=1 from DEV_ACK entry to STOP or to IGNORE entry.
// TESTING
//  T1 write: START,42,12,14,STOP -> ACK on all 3 bytes; reg[12]=14; exactly one wr_strobe (addr 12, data 14).
//  T2 read: after T1, START,42,12,STOP,START,43 -> ACK; slave returns 8'h14; master NACK, STOP -> SDA z, busy=0.
//  T3 repeated start: START,42,3A,Sr,43 -> returns reg[3A]=RST_VAL; no wr_strobe pulses.
//  T4 wrong addr: START,44,12,55,STOP -> SDA never driven low; reg[12] unchanged; wr_strobe never pulses.
//  T5 burst+wrap: START,42,FF,A1,A2,A3,STOP -> reg[FF]=A1, reg[00]=A2, reg[01]=A3; three wr_strobe pulses.
//  T6 reset mid-read: rst_n=0 while driving a 0 data bit -> SDA z within 0 iCLK; all regs=RST_VAL afterwards.
//  All tests: check SDA never changes while SCL=1 except at START/STOP, which the master generates.

Source files
------------

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C responder with an internal 8-bit register file, oversampling SCL/SDA on iCLK.
// Accepts 3-phase writes (dev, sub, data...) and 2-phase reads (dev|R, data...).
module sccb_slave_regfile #(
    parameter logic [7:0] SLAVE_ADDR = 8'h42,
    parameter int         REG_DEPTH  = 256,
    parameter logic [7:0] RST_VAL    = 8'h00
) (
    input  logic       iCLK,
    input  logic       rst_n,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t          state_q, state_d;
    logic            scl_s1_q, scl_s2_q, scl_d1_q;
    logic            sda_s1_q, sda_s2_q, sda_d1_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   sub_addr_q, sub_addr_d;
    logic            sda_oe_q, sda_oe_d;
    logic            ack_phase_q, ack_phase_d;
    logic            rw_q, rw_d;
    logic            busy_q, busy_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [7:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      regs_q [REG_DEPTH];
    logic            reg_we;
    logic [7:0]      reg_wdata;

    logic            scl_rise, scl_fall, start_c, stop_c, last_bit, addr_match;
    logic [7:0]      rx_byte, sub_ext;
    logic [AW-1:0]   sub_next;

    // Bus idles high, so the synchronisers reset to 1 to avoid phantom edges.
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_d1_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d1_q <= 1'b1;
        end else begin
            scl_s1_q <= I2C_SCLK;
            scl_s2_q <= scl_s1_q;
            scl_d1_q <= scl_s2_q;
            sda_s1_q <= I2C_SDAT;
            sda_s2_q <= sda_s1_q;
            sda_d1_q <= sda_s2_q;
        end
    end

    assign scl_rise   = scl_s2_q & ~scl_d1_q;
    assign scl_fall   = ~scl_s2_q & scl_d1_q;
    assign start_c    = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
    assign stop_c     = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;
    assign rx_byte    = {shift_q[6:0], sda_s2_q};
    assign last_bit   = (bit_cnt_q == 3'd7);
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDR[7:1]);
    assign sub_next   = sub_addr_q + 1'b1;

    always_comb begin
        sub_ext = '0;
        sub_ext[AW-1:0] = sub_addr_q;
    end

    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_c) begin
            state_d = IDLE;
        end else if (start_c) begin
            state_d = DEV_ADDR;
        end else begin
            case (state_q)
                DEV_ADDR: if (scl_rise && last_bit) state_d = addr_match ? DEV_ACK : IGNORE;
                DEV_ACK:  if (scl_fall && ack_phase_q) state_d = rw_q ? RD_DATA : SUB_ADDR;
                SUB_ADDR: if (scl_rise && last_bit) state_d = SUB_ACK;
                SUB_ACK:  if (scl_fall && ack_phase_q) state_d = WR_DATA;
                WR_DATA:  if (scl_rise && last_bit) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && ack_phase_q) state_d = WR_DATA;
                RD_DATA:  if (scl_fall && last_bit) state_d = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s2_q)         state_d = IGNORE;
                    else if (scl_fall && ack_phase_q) state_d = RD_DATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // ACK states use ack_phase: first SCL fall pulls SDA low, second fall releases it.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sub_addr_d  = sub_addr_q;
        sda_oe_d    = sda_oe_q;
        ack_phase_d = ack_phase_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;
        reg_wdata   = rx_byte;
        if (stop_c) begin
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
        end else if (start_c) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, SUB_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d     = rx_byte;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        ack_phase_d = 1'b0;
                        if (last_bit && state_q == DEV_ADDR) begin
                            rw_d   = rx_byte[0];
                            busy_d = addr_match;
                            if (addr_match && rx_byte[0]) shift_d = regs_q[sub_addr_q];
                        end
                        if (last_bit && state_q == SUB_ADDR) sub_addr_d = rx_byte[AW-1:0];
                        if (last_bit && state_q == WR_DATA) begin
                            reg_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = sub_ext;
                            wr_data_d   = rx_byte;
                            sub_addr_d  = sub_next;
                        end
                    end
                end
                DEV_ACK, SUB_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            sda_oe_d    = (state_q == DEV_ACK && rw_q) ? ~shift_q[7] : 1'b0;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (last_bit) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            busy_d = 1'b0;
                        end else begin
                            sub_addr_d  = sub_next;
                            shift_d     = regs_q[sub_next];
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        sda_oe_d    = ~shift_q[7];
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            sub_addr_q  <= '0;
            sda_oe_q    <= 1'b0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sub_addr_q  <= sub_addr_d;
            sda_oe_q    <= sda_oe_d;
            ack_phase_q <= ack_phase_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= RST_VAL;
        end else if (reg_we) begin
            regs_q[sub_addr_q] <= reg_wdata;
        end
    end

    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile: a bit-banged SCCB master with an open-drain bus,
// table-driven write transactions and register readbacks, plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_sccb_slave_regfile;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    wire        sda_bus;
    logic       wr_strobe, busy;
    logic [7:0] wr_addr, wr_data;

    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];

    assign sda_bus = sda_m ? 1'bz : 1'b0;
    pullup (sda_bus);

    always #5 clk = ~clk;

    sccb_slave_regfile #(.SLAVE_ADDR(8'h42), .REG_DEPTH(256), .RST_VAL(8'h00)) dut (
        .iCLK(clk), .rst_n(rst_n), .I2C_SCLK(scl_m), .I2C_SDAT(sda_bus),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    typedef struct {
        logic [2:0][7:0] b;
        int              n;
        logic [2:0]      ack;
        int              strb;
        logic [7:0]      wa;
        logic [7:0]      wd;
    } wvec_t;

    typedef struct {
        logic [7:0] sub;
        logic [7:0] exp;
    } rvec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: with the master releasing SDA and SCL held high, SDA must not move.
    logic scl_prev = 1'b1, sda_m_prev = 1'b1, sda_prev = 1'b1, rst_prev = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (rst_n && rst_prev && scl_m && scl_prev && sda_m && sda_m_prev) begin
            checks++;
            if (sda_bus !== sda_prev) begin
                errors++;
                $display("FAIL sda_stable_scl_high: got %b, expected %b at %0t", sda_bus, sda_prev, $time);
            end
        end
        if (rst_n && wr_strobe) begin
            strobe_cnt++;
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        scl_prev   = scl_m;
        sda_m_prev = sda_m;
        sda_prev   = sda_bus;
        rst_prev   = rst_n;
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic v);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        v = sda_bus; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(nack);
    endtask

    task automatic read_reg(input logic [7:0] sub, output logic [7:0] d, output logic [2:0] acks);
        logic a;
        m_start();
        write_byte(8'h42, a); acks[0] = a;
        write_byte(sub, a);   acks[1] = a;
        m_stop();
        m_start();
        write_byte(8'h43, a); acks[2] = a;
        read_byte(d, 1'b1);
        m_stop();
    endtask

    wvec_t wv [5];
    rvec_t rv [6];

    initial begin
        logic       a;
        logic [2:0] acks;
        logic [7:0] d;
        int         s0;

        wv[0] = '{b: {8'h42, 8'h12, 8'h14}, n: 3, ack: 3'b000, strb: 1, wa: 8'h12, wd: 8'h14};
        wv[1] = '{b: {8'h44, 8'h12, 8'h55}, n: 3, ack: 3'b111, strb: 0, wa: 8'h00, wd: 8'h00};
        wv[2] = '{b: {8'h42, 8'h30, 8'h5A}, n: 3, ack: 3'b000, strb: 1, wa: 8'h30, wd: 8'h5A};
        wv[3] = '{b: {8'h42, 8'h31, 8'h00}, n: 2, ack: 3'b000, strb: 0, wa: 8'h00, wd: 8'h00};
        wv[4] = '{b: {8'h40, 8'h12, 8'h99}, n: 3, ack: 3'b111, strb: 0, wa: 8'h00, wd: 8'h00};

        rv[0] = '{sub: 8'h12, exp: 8'h14};
        rv[1] = '{sub: 8'h30, exp: 8'h5A};
        rv[2] = '{sub: 8'hFF, exp: 8'hA1};
        rv[3] = '{sub: 8'h00, exp: 8'hA2};
        rv[4] = '{sub: 8'h01, exp: 8'hA3};
        rv[5] = '{sub: 8'h3A, exp: 8'h00};

        repeat (4) @(negedge clk);
        chk("reset_sda", 32'(sda_bus), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wr_strobe", 32'(wr_strobe), 32'h0);
        chk("reset_wr_addr", 32'(wr_addr), 32'h0);
        chk("reset_wr_data", 32'(wr_data), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            s0 = strobe_cnt;
            acks = 3'b000;
            m_start();
            for (int k = 0; k < wv[v].n; k++) begin
                write_byte(wv[v].b[2-k], a);
                acks[k] = a;
            end
            m_stop();
            chk($sformatf("wr%0d_acks", v), 32'(acks), 32'(wv[v].ack));
            chk($sformatf("wr%0d_strobes", v), 32'(strobe_cnt - s0), 32'(wv[v].strb));
            chk($sformatf("wr%0d_busy_after_stop", v), 32'(busy), 32'h0);
            if (wv[v].strb > 0 && strobe_cnt > s0) begin
                chk($sformatf("wr%0d_wr_addr", v), 32'(log_addr[s0]), 32'(wv[v].wa));
                chk($sformatf("wr%0d_wr_data", v), 32'(log_data[s0]), 32'(wv[v].wd));
            end
        end

        // Read of reg[12] with busy tracking and a final NACK.
        s0 = strobe_cnt;
        m_start();
        write_byte(8'h42, a); chk("t2_dev_ack", 32'(a), 32'h0);
        write_byte(8'h12, a); chk("t2_sub_ack", 32'(a), 32'h0);
        m_stop();
        m_start();
        write_byte(8'h43, a); chk("t2_rd_ack", 32'(a), 32'h0);
        chk("t2_busy_during_read", 32'(busy), 32'h1);
        read_byte(d, 1'b1);
        chk("t2_read_data", 32'(d), 32'h14);
        m_stop();
        chk("t2_sda_released", 32'(sda_bus), 32'h1);
        chk("t2_busy_after_stop", 32'(busy), 32'h0);
        chk("t2_no_strobe", 32'(strobe_cnt - s0), 32'h0);

        // Repeated START switches straight from write-address phase to read.
        s0 = strobe_cnt;
        m_start();
        write_byte(8'h42, a); chk("t3_dev_ack", 32'(a), 32'h0);
        write_byte(8'h3A, a); chk("t3_sub_ack", 32'(a), 32'h0);
        m_start();
        write_byte(8'h43, a); chk("t3_rd_ack", 32'(a), 32'h0);
        read_byte(d, 1'b1);
        m_stop();
        chk("t3_read_data", 32'(d), 32'h00);
        chk("t3_no_strobe", 32'(strobe_cnt - s0), 32'h0);

        // Burst write wrapping from FF to 00.
        s0 = strobe_cnt;
        acks = 3'b000;
        m_start();
        write_byte(8'h42, a); acks[0] = a;
        write_byte(8'hFF, a); acks[1] = a;
        write_byte(8'hA1, a); acks[2] = a;
        write_byte(8'hA2, a); chk("t5_ack_a2", 32'(a), 32'h0);
        write_byte(8'hA3, a); chk("t5_ack_a3", 32'(a), 32'h0);
        m_stop();
        chk("t5_acks", 32'(acks), 32'h0);
        chk("t5_strobes", 32'(strobe_cnt - s0), 32'h3);
        if (strobe_cnt - s0 == 3) begin
            chk("t5_addr0", 32'(log_addr[s0]), 32'hFF);
            chk("t5_data0", 32'(log_data[s0]), 32'hA1);
            chk("t5_addr1", 32'(log_addr[s0+1]), 32'h00);
            chk("t5_data1", 32'(log_data[s0+1]), 32'hA2);
            chk("t5_addr2", 32'(log_addr[s0+2]), 32'h01);
            chk("t5_data2", 32'(log_data[s0+2]), 32'hA3);
        end

        for (int r = 0; r < 6; r++) begin
            read_reg(rv[r].sub, d, acks);
            chk($sformatf("rd_%0h_acks", rv[r].sub), 32'(acks), 32'h0);
            chk($sformatf("rd_%0h_data", rv[r].sub), 32'(d), 32'(rv[r].exp));
        end

        // Reset while the slave is pulling SDA low for a 0 data bit (reg[12] = 14, MSB 0).
        m_start();
        write_byte(8'h42, a);
        write_byte(8'h12, a);
        m_stop();
        m_start();
        write_byte(8'h43, a); chk("t6_rd_ack", 32'(a), 32'h0);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        chk("t6_bit_driven_low", 32'(sda_bus), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t6_sda_released_async", 32'(sda_bus), 32'h1);
        repeat (3) @(negedge clk);
        chk("t6_busy_in_reset", 32'(busy), 32'h0);
        chk("t6_wr_addr_in_reset", 32'(wr_addr), 32'h0);
        rst_n = 1'b1;
        qwait();
        scl_m = 1'b0; qwait();
        m_stop();
        read_reg(8'h12, d, acks);
        chk("t6_rd12_acks", 32'(acks), 32'h0);
        chk("t6_rd12_data", 32'(d), 32'h00);
        read_reg(8'hFF, d, acks);
        chk("t6_rdff_data", 32'(d), 32'h00);
        read_reg(8'h30, d, acks);
        chk("t6_rd30_data", 32'(d), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
